// File: rtl/drone_rx_mem_arb.sv
// drone_rx_mem_arb
// Arbitrates the single-port frame-buffer RAM between the RX pixel writer and
// the display reader. Bursts alternate round-robin, and the writer wins ties
// from IDLE. Each grant lasts at most MAX_BURST beats. A starvation counter
// preempts a writer burst once the reader has waited STARVE_LIM cycles.
//
// Ports:
//   sys_clock            system clock, rising edge
//   rst                  asynchronous active-high reset
//   wr_req/addr/data     writer beat request
//   wr_gnt               writer beat accepted this cycle (combinational)
//   rd_req/addr          reader beat request
//   rd_gnt               reader beat accepted this cycle (combinational)
//   rd_data              read data, passthrough of mem_rdata
//   rd_valid             rd_data valid, one cycle after rd_gnt (registered)
//   mem_en/we/addr/wdata RAM command
//   mem_rdata            RAM read data, 1-cycle latency
module drone_rx_mem_arb #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int MAX_BURST  = 16,
  parameter int STARVE_LIM = 64
) (
  input  logic              sys_clock,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WR   = 2'b01,
    RD   = 2'b10
  } state_t;

  state_t          state_r, state_nxt;
  logic [BW-1:0]   beat_cnt_r, beat_cnt_nxt;
  logic [SW-1:0]   starve_cnt_r, starve_cnt_nxt;
  logic            rd_valid_r;
  logic            burst_end_s;

  // Grants and RAM command mux; the address mux defaults to the reader.
  always_comb begin
    wr_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    mem_addr  = rd_addr;
    mem_wdata = wr_data;
    if (state_r == WR) begin
      wr_gnt   = wr_req;
      mem_addr = wr_addr;
    end else if (state_r == RD) begin
      rd_gnt = rd_req;
    end else begin
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
    end
    mem_en = wr_gnt | rd_gnt;
    mem_we = wr_gnt;
  end

  // Starvation counter: counts reader wait cycles, saturating at the limit.
  always_comb begin
    starve_cnt_nxt = '0;
    if (rd_req && !rd_gnt) begin
      if (starve_cnt_r == STARVE_MAX) begin
        starve_cnt_nxt = STARVE_MAX;
      end else begin
        starve_cnt_nxt = starve_cnt_r + SW'(1);
      end
    end else begin
      starve_cnt_nxt = '0;
    end
  end

  // Next-state and beat counter. At burst end the other requester goes first,
  // then the same requester re-arms, then IDLE. The change is direct, with no
  // dead cycle in between.
  always_comb begin
    state_nxt    = state_r;
    beat_cnt_nxt = beat_cnt_r;
    burst_end_s  = 1'b0;
    case (state_r)
      IDLE: begin
        beat_cnt_nxt = '0;
        if (rd_req && (starve_cnt_r == STARVE_MAX)) begin
          state_nxt = RD;
        end else if (wr_req) begin
          state_nxt = WR;
        end else if (rd_req) begin
          state_nxt = RD;
        end else begin
          state_nxt = IDLE;
        end
      end
      WR: begin
        // Starvation is judged after the current beat, so use the next count.
        burst_end_s = !wr_req || (wr_gnt && (beat_cnt_r == BEAT_LAST)) ||
                      (starve_cnt_nxt == STARVE_MAX);
        if (burst_end_s) begin
          beat_cnt_nxt = '0;
          if (rd_req) begin
            state_nxt = RD;
          end else if (wr_req) begin
            state_nxt = WR;
          end else begin
            state_nxt = IDLE;
          end
        end else if (wr_gnt) begin
          beat_cnt_nxt = beat_cnt_r + BW'(1);
        end else begin
          beat_cnt_nxt = beat_cnt_r;
        end
      end
      RD: begin
        burst_end_s = !rd_req || (rd_gnt && (beat_cnt_r == BEAT_LAST));
        if (burst_end_s) begin
          beat_cnt_nxt = '0;
          if (wr_req) begin
            state_nxt = WR;
          end else if (rd_req) begin
            state_nxt = RD;
          end else begin
            state_nxt = IDLE;
          end
        end else if (rd_gnt) begin
          beat_cnt_nxt = beat_cnt_r + BW'(1);
        end else begin
          beat_cnt_nxt = beat_cnt_r;
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  // State, counters and the read-valid pipeline stage.
  always_ff @(posedge sys_clock or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      beat_cnt_r   <= '0;
      starve_cnt_r <= '0;
      rd_valid_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      beat_cnt_r   <= beat_cnt_nxt;
      starve_cnt_r <= starve_cnt_nxt;
      rd_valid_r   <= rd_gnt;
    end
  end

  assign rd_valid = rd_valid_r;
  assign rd_data  = mem_rdata;

endmodule
